ysyx_store_queue: RTL

Post-commit store buffer between the reorder unit's store-retire port and the LSU bus store channel. Stores retired by the ROU are captured in order into a circular FIFO, aligned into byte lanes, and drained one at a time onto the bus through a valid/ready handshake. A combinational address-conflict check lets the load path stall any load that overlaps a buffered store. It also reports empty status so fence and `fence_i` retirement can wait for all stores to drain.

---
 rtl/ysyx_store_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ysyx_store_queue.sv
// ysyx_store_queue: post-commit store buffer. Retired stores are queued in order,
// aligned into byte lanes and drained one at a time onto the LSU store channel.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_store_queue #(
    parameter int XLEN    = `YSYX_XLEN,
    parameter int SQ_SIZE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [4:0]      commit_alu,
    input  logic [XLEN-1:0] commit_addr,
    input  logic [XLEN-1:0] commit_data,
    output logic            commit_ready,
    output logic            bus_awvalid,
    output logic [XLEN-1:0] bus_awaddr,
    output logic            bus_wvalid,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wstrb,
    input  logic            bus_wready,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_conflict,
    output logic            sq_empty
);
    localparam int IW = $clog2(SQ_SIZE);
    localparam int PW = IW + 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] mem_addr [SQ_SIZE];
    logic [XLEN-1:0] mem_data [SQ_SIZE];
    logic [1:0]      mem_size [SQ_SIZE];

    logic [PW-1:0]   head, tail, count;
    logic [IW-1:0]   head_idx, tail_idx, slot_offset;
    logic            full, empty, enq, pop, launch;
    logic [1:0]      head_off;
    logic [3:0]      head_base, head_strb, strb_q;
    logic [XLEN-1:0] head_wdata;
    logic            unused_bits;

    assign head_idx     = head[IW-1:0];
    assign tail_idx     = tail[IW-1:0];
    assign count        = tail - head;
    assign full         = (head_idx == tail_idx) && (head[IW] != tail[IW]);
    assign empty        = (head == tail);
    assign commit_ready = !full;
    assign enq          = commit_valid && !full;
    assign sq_empty     = empty && (state == IDLE);
    assign bus_wstrb    = {4'b0000, strb_q};
    assign unused_bits  = ^{commit_alu[4:2], ld_addr[1:0]};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem_addr[tail_idx] <= commit_addr;
            mem_data[tail_idx] <= commit_data;
            mem_size[tail_idx] <= commit_alu[1:0];
        end
    end

    always_comb begin
        head_off = mem_addr[head_idx][1:0];
        unique case (mem_size[head_idx])
            2'b00:   head_base = 4'b0001;
            2'b01:   head_base = 4'b0011;
            default: head_base = 4'b1111;
        endcase
        head_strb  = head_base << head_off;
        head_wdata = mem_data[head_idx] << {head_off, 3'b000};
    end

    // Word-granular overlap against every live slot plus the store entering now.
    always_comb begin
        ld_conflict = enq && (commit_addr[XLEN-1:2] == ld_addr[XLEN-1:2]);
        slot_offset = '0;
        for (int i = 0; i < SQ_SIZE; i++) begin
            slot_offset = IW'(i) - head_idx;
            if (({1'b0, slot_offset} < count) &&
                (mem_addr[i][XLEN-1:2] == ld_addr[XLEN-1:2]))
                ld_conflict = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (!empty)     state_next = SEND;
            SEND: if (bus_wready) state_next = IDLE;
        endcase
    end

    always_comb begin
        launch      = (state == IDLE) && !empty;
        pop         = (state == SEND) && bus_wready;
        bus_awvalid = (state == SEND);
        bus_wvalid  = (state == SEND);
    end

    // Bus payload is captured once on launch and held steady through SEND.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_awaddr <= '0;
            bus_wdata  <= '0;
            strb_q     <= '0;
        end else if (launch) begin
            bus_awaddr <= mem_addr[head_idx];
            bus_wdata  <= head_wdata;
            strb_q     <= head_strb;
        end
    end

endmodule
